// File: rtl/bus_fabric.sv
// Single-master, multi-slave memory-mapped interconnect with registered decode,
// per-slave valid/ready handshake, timeout abort and first-error capture.
module bus_fabric #(
  parameter int unsigned          SLAVES     = 4,
  parameter logic [SLAVES*32-1:0] SLAVE_BASE = '0,
  parameter logic [SLAVES*32-1:0] SLAVE_MASK = '0,
  parameter int unsigned          TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m_valid,
  input  logic [31:0]          m_addr,
  input  logic [31:0]          m_wdata,
  input  logic [3:0]           m_wstrb,
  output logic                 m_ready,
  output logic [31:0]          m_rdata,
  output logic                 m_err,
  output logic [SLAVES-1:0]    s_sel,
  output logic [31:0]          s_addr,
  output logic [31:0]          s_wdata,
  output logic [3:0]           s_wstrb,
  input  logic [SLAVES-1:0]    s_ready,
  input  logic [SLAVES*32-1:0] s_rdata,
  output logic                 err_valid,
  output logic [31:0]          err_addr,
  output logic [1:0]           err_code,
  output logic [7:0]           err_count,
  input  logic                 err_clear
);

  localparam int unsigned IDX_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [1:0] ERR_UNMAPPED = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  wait_q, wait_d;

  logic              m_ready_d, m_err_d;
  logic [31:0]       m_rdata_d;
  logic [SLAVES-1:0] s_sel_d;
  logic [31:0]       s_addr_d, s_wdata_d;
  logic [3:0]        s_wstrb_d;
  logic              err_valid_d;
  logic [31:0]       err_addr_d;
  logic [1:0]        err_code_d;
  logic [7:0]        err_count_d;

  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic              sel_ready;
  logic [31:0]       sel_rdata;
  logic              err_new;
  logic [1:0]        err_new_code;
  logic [31:0]       err_new_addr;

  // Address decode: walk downwards so the lowest matching index is the last one written.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = int'(SLAVES) - 1; i >= 0; i--) begin
      if ((m_addr & SLAVE_MASK[32*i +: 32]) ==
          (SLAVE_BASE[32*i +: 32] & SLAVE_MASK[32*i +: 32])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Ready/read-data of the slave currently being accessed; other slaves are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < int'(SLAVES); i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[32*i +: 32];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wait_d       = wait_q;
    m_ready_d    = 1'b0;
    m_err_d      = 1'b0;
    m_rdata_d    = m_rdata;
    s_sel_d      = s_sel;
    s_addr_d     = s_addr;
    s_wdata_d    = s_wdata;
    s_wstrb_d    = s_wstrb;
    err_valid_d  = err_valid;
    err_addr_d   = err_addr;
    err_code_d   = err_code;
    err_count_d  = err_count;
    err_new      = 1'b0;
    err_new_code = ERR_UNMAPPED;
    err_new_addr = m_addr;

    case (state_q)
      ST_IDLE: begin
        if (m_valid) begin
          s_addr_d  = m_addr;
          s_wdata_d = m_wdata;
          s_wstrb_d = m_wstrb;
          if (hit) begin
            state_d = ST_ACCESS;
            idx_d   = hit_idx;
            wait_d  = '0;
            s_sel_d = SLAVES'(1) << hit_idx;
          end else begin
            state_d      = ST_RESP;
            m_ready_d    = 1'b1;
            m_err_d      = 1'b1;
            m_rdata_d    = '0;
            err_new      = 1'b1;
            err_new_code = ERR_UNMAPPED;
            err_new_addr = m_addr;
          end
        end
      end
      ST_ACCESS: begin
        if (sel_ready) begin
          state_d   = ST_RESP;
          m_ready_d = 1'b1;
          m_rdata_d = (s_wstrb == 4'b0000) ? sel_rdata : 32'h0;
          s_sel_d   = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d      = ST_RESP;
          m_ready_d    = 1'b1;
          m_err_d      = 1'b1;
          m_rdata_d    = '0;
          s_sel_d      = '0;
          err_new      = 1'b1;
          err_new_code = ERR_TIMEOUT;
          err_new_addr = s_addr;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        s_sel_d = '0;
      end
    endcase

    // A new error outranks a simultaneous clear and restarts the count at 1.
    if (err_new) begin
      if (err_clear || !err_valid) begin
        err_valid_d = 1'b1;
        err_addr_d  = err_new_addr;
        err_code_d  = err_new_code;
      end
      if (err_clear) begin
        err_count_d = 8'd1;
      end else if (err_count != 8'hFF) begin
        err_count_d = err_count + 8'd1;
      end
    end else if (err_clear) begin
      err_valid_d = 1'b0;
      err_addr_d  = '0;
      err_code_d  = '0;
      err_count_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      wait_q    <= '0;
      m_ready   <= 1'b0;
      m_err     <= 1'b0;
      m_rdata   <= '0;
      s_sel     <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_code  <= '0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      m_ready   <= m_ready_d;
      m_err     <= m_err_d;
      m_rdata   <= m_rdata_d;
      s_sel     <= s_sel_d;
      s_addr    <= s_addr_d;
      s_wdata   <= s_wdata_d;
      s_wstrb   <= s_wstrb_d;
      err_valid <= err_valid_d;
      err_addr  <= err_addr_d;
      err_code  <= err_code_d;
      err_count <= err_count_d;
    end
  end

endmodule
